// File: rtl/mips_pkg.sv
// Shared MIPS datapath constants: widths and architectural register indices.
// The register bank takes its parameter defaults from here.
package mips_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 1 << ADDR_W;

  localparam int REG_ZERO = 0;
  localparam int REG_SP   = 29;
  localparam int REG_RA   = 31;

  localparam int SP_RESET = 227;

  typedef logic [ADDR_W-1:0] regIdx_t;

  // Writes aimed at $zero are architecturally discarded.
  function automatic logic isWritable(input logic we, input regIdx_t idx);
    return we && (idx != regIdx_t'(REG_ZERO));
  endfunction

endpackage

// File: rtl/reg_bank_if.sv
// Register-bank access bus: read/write indices, write data, operand latch
// controls, and the combinational and latched read results.
interface reg_bank_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);

  logic              reg_write;
  logic [ADDR_W-1:0] read_reg1;
  logic [ADDR_W-1:0] read_reg2;
  logic [ADDR_W-1:0] write_reg;
  logic [DATA_W-1:0] write_data;
  logic              load_a;
  logic              load_b;
  logic [DATA_W-1:0] read_data1;
  logic [DATA_W-1:0] read_data2;
  logic [DATA_W-1:0] a_out;
  logic [DATA_W-1:0] b_out;

  modport master (
    output reg_write, read_reg1, read_reg2, write_reg, write_data,
           load_a, load_b,
    input  read_data1, read_data2, a_out, b_out
  );

  modport slave (
    input  reg_write, read_reg1, read_reg2, write_reg, write_data,
           load_a, load_b,
    output read_data1, read_data2, a_out, b_out
  );

endinterface

// File: rtl/reg_bank_op_latch.sv
// ALU operand latch: DATA_W-wide register with synchronous clear and load
// enable; holds its value whenever load is low.
module op_latch #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  logic [DATA_W-1:0] q_p1;

  always_ff @(posedge clk) begin
    if (reset) begin
      q_p1 <= '0;
    end else if (load) begin
      q_p1 <= d;
    end
  end

  assign q = q_p1;

endmodule

// File: rtl/reg_bank.sv
// 32-entry MIPS general-purpose register file: two combinational read ports,
// one synchronous write port, and the A/B operand latches feeding the ALU.
module reg_bank #(
  parameter int                       DATA_W   = mips_pkg::DATA_W,
  parameter int                       ADDR_W   = mips_pkg::ADDR_W,
  parameter int                       SP_IDX   = mips_pkg::REG_SP,
  parameter logic [DATA_W-1:0]        SP_RESET = DATA_W'(mips_pkg::SP_RESET)
) (
  input logic       clk,
  input logic       reset,
  reg_bank_if.slave bus
);

  import mips_pkg::*;

  localparam int NREGS = 1 << ADDR_W;

  logic [DATA_W-1:0] regs [NREGS];
  logic              wrEn;
  logic [DATA_W-1:0] rd1Data;
  logic [DATA_W-1:0] rd2Data;
  logic [DATA_W-1:0] aOut_p1;
  logic [DATA_W-1:0] bOut_p1;

  assign wrEn = bus.reg_write && (bus.write_reg != '0);

  // ---- stage p0: array write; reset restores the architectural boot state
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= (i == SP_IDX) ? SP_RESET : '0;
      end
    end else if (wrEn) begin
      regs[bus.write_reg] <= bus.write_data;
    end
  end

  // No bypass: a same-cycle write is only visible after the edge, which is
  // also what gives the operand latches the pre-write value.
  assign rd1Data = (bus.read_reg1 == '0) ? '0 : regs[bus.read_reg1];
  assign rd2Data = (bus.read_reg2 == '0) ? '0 : regs[bus.read_reg2];

  assign bus.read_data1 = rd1Data;
  assign bus.read_data2 = rd2Data;

  // ---- stage p1: operand latches
  op_latch #(.DATA_W(DATA_W)) uLatchA (
    .clk   (clk),
    .reset (reset),
    .load  (bus.load_a),
    .d     (rd1Data),
    .q     (aOut_p1)
  );

  op_latch #(.DATA_W(DATA_W)) uLatchB (
    .clk   (clk),
    .reset (reset),
    .load  (bus.load_b),
    .d     (rd2Data),
    .q     (bOut_p1)
  );

  assign bus.a_out = aOut_p1;
  assign bus.b_out = bOut_p1;

endmodule

// File: tb/tb_reg_bank.sv
// Scoreboard bench for reg_bank: stimulus queues expected values, a negedge
// monitor pops them and compares against the selected DUT output.
module tb_reg_bank;

  localparam int DW = 32;
  localparam int AW = 5;

  typedef enum logic [1:0] {S_RD1, S_RD2, S_A, S_B} sel_e;

  typedef struct {
    sel_e        sel;
    logic [31:0] val;
    string       name;
  } exp_t;

  logic clk;
  logic reset;
  exp_t sbQ[$];
  int   nCompared;
  int   nFailed;

  reg_bank_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  reg_bank dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: compare every queued expectation against the outputs at negedge.
  always @(negedge clk) begin
    while (sbQ.size() > 0) begin
      exp_t        e;
      logic [31:0] act;
      e = sbQ.pop_front();
      case (e.sel)
        S_RD1:   act = bus.read_data1;
        S_RD2:   act = bus.read_data2;
        S_A:     act = bus.a_out;
        default: act = bus.b_out;
      endcase
      nCompared++;
      if (act !== e.val) begin
        nFailed++;
        $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, act, e.val);
      end
    end
  end

  task automatic expectVal(input sel_e s, input logic [31:0] v, input string nm);
    exp_t e;
    e.sel  = s;
    e.val  = v;
    e.name = nm;
    sbQ.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkNow();
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    bus.reg_write  = 1'b0;
    bus.write_reg  = '0;
    bus.write_data = '0;
    bus.load_a     = 1'b0;
    bus.load_b     = 1'b0;
  endtask

  task automatic writeReg(input logic [4:0] idx, input logic [31:0] d);
    bus.reg_write  = 1'b1;
    bus.write_reg  = idx;
    bus.write_data = d;
    tick();
    idle();
  endtask

  initial begin
    nCompared = 0;
    nFailed   = 0;
    reset     = 1'b1;
    idle();
    bus.read_reg1 = '0;
    bus.read_reg2 = '0;
    tick();
    tick();
    reset = 1'b0;

    // Reset state of all registers through both ports, and both latches
    for (int i = 0; i < 32; i++) begin
      logic [4:0] i1;
      logic [4:0] i2;
      i1 = 5'(i);
      i2 = 5'(31 - i);
      bus.read_reg1 = i1;
      bus.read_reg2 = i2;
      expectVal(S_RD1, (i == 29) ? 32'd227 : 32'd0, $sformatf("reset_rd1[%0d]", i));
      expectVal(S_RD2, (31 - i == 29) ? 32'd227 : 32'd0, $sformatf("reset_rd2[%0d]", 31 - i));
      checkNow();
    end
    expectVal(S_A, 32'd0, "reset_a");
    expectVal(S_B, 32'd0, "reset_b");
    checkNow();

    // Write then read, with the same-cycle read still showing the old value
    tick();
    bus.read_reg1  = 5'd8;
    bus.reg_write  = 1'b1;
    bus.write_reg  = 5'd8;
    bus.write_data = 32'hDEADBEEF;
    expectVal(S_RD1, 32'h0, "wr_same_cycle");
    checkNow();
    tick();
    idle();
    expectVal(S_RD1, 32'hDEADBEEF, "wr_next_cycle");
    checkNow();

    // $zero ignores writes
    tick();
    bus.read_reg1 = 5'd0;
    bus.read_reg2 = 5'd0;
    writeReg(5'd0, 32'hFFFFFFFF);
    expectVal(S_RD1, 32'h0, "zero_rd1");
    expectVal(S_RD2, 32'h0, "zero_rd2");
    checkNow();

    // Latch ordering: B loads reg 8 while reg 5 is set to 0x11
    tick();
    bus.read_reg2  = 5'd8;
    bus.load_b     = 1'b1;
    writeReg(5'd5, 32'h11);
    // Same edge: write reg 5 = 0x22 and load A from reg 5
    bus.read_reg1  = 5'd5;
    bus.read_reg2  = 5'd5;
    bus.reg_write  = 1'b1;
    bus.write_reg  = 5'd5;
    bus.write_data = 32'h22;
    bus.load_a     = 1'b1;
    tick();
    idle();
    expectVal(S_A,   32'h11,       "order_a_prewrite");
    expectVal(S_RD1, 32'h22,       "order_rd1_postwrite");
    expectVal(S_B,   32'hDEADBEEF, "order_b_hold");
    checkNow();

    // Dual read of reg 31 and simultaneous loads
    tick();
    writeReg(5'd31, 32'h400);
    bus.read_reg1 = 5'd31;
    bus.read_reg2 = 5'd31;
    bus.load_a    = 1'b1;
    bus.load_b    = 1'b1;
    expectVal(S_RD1, 32'h400, "dual_rd1");
    expectVal(S_RD2, 32'h400, "dual_rd2");
    checkNow();
    tick();
    idle();
    bus.read_reg1 = 5'd8;
    bus.read_reg2 = 5'd5;
    expectVal(S_A, 32'h400, "dual_a");
    expectVal(S_B, 32'h400, "dual_b");
    checkNow();
    tick();
    expectVal(S_A, 32'h400, "hold_a");
    expectVal(S_B, 32'h400, "hold_b");
    checkNow();

    // Stack pointer is an ordinary register once out of reset
    tick();
    writeReg(5'd29, 32'h5555);
    bus.read_reg1 = 5'd29;
    expectVal(S_RD1, 32'h5555, "sp_writable");
    checkNow();

    // Reset overrides a concurrent write and loads
    tick();
    reset          = 1'b1;
    bus.reg_write  = 1'b1;
    bus.write_reg  = 5'd29;
    bus.write_data = 32'h1234;
    bus.load_a     = 1'b1;
    bus.load_b     = 1'b1;
    bus.read_reg1  = 5'd29;
    bus.read_reg2  = 5'd31;
    tick();
    reset = 1'b0;
    idle();
    expectVal(S_RD1, 32'd227, "rst_mid_sp");
    expectVal(S_RD2, 32'h0,   "rst_mid_r31");
    expectVal(S_A,   32'h0,   "rst_mid_a");
    expectVal(S_B,   32'h0,   "rst_mid_b");
    checkNow();
    bus.read_reg1 = 5'd8;
    bus.read_reg2 = 5'd5;
    expectVal(S_RD1, 32'h0, "rst_mid_r8");
    expectVal(S_RD2, 32'h0, "rst_mid_r5");
    checkNow();

    // Drain the scoreboard with a bounded wait
    for (int k = 0; k < 10 && sbQ.size() > 0; k++) checkNow();
    if (sbQ.size() > 0) begin
      nFailed++;
      $display("FAIL drain: %0d entries left, expected 0", sbQ.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nFailed);
    $finish;
  end

endmodule
